// File: rtl/xg_ifetch_if.sv
// xg_ifetch bus bundle: instruction-memory port, redirect and decode handshake.
// master = fetch stage, slave = memory/decode environment.
interface xg_ifetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        redirect;
    logic [31:0] redirect_pc;

    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output id_valid,
        output id_instr,
        output id_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        output id_ready
    );

endinterface

// File: rtl/xg_ifetch.sv
// xg_ifetch: instruction fetch stage, one outstanding imem read, small queue.
// Optional macro XG_IF_BYPASS_EN: forward a response to decode when queue empty.
module xg_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    xg_ifetch_if.master bus
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic [31:0]   req_pc_q;
    logic [31:0]   req_pc_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;

    logic [31:0]   q_instr_q [QDEPTH];
    logic [31:0]   q_pc_q    [QDEPTH];

    logic          head_valid;
    logic          rvalid_keep;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          issue;
    logic [CW-1:0] next_count;

    // Queue occupancy, push/pop qualification and the request-issue decision.
    always_comb begin
        head_valid  = (count_q != '0);
        rvalid_keep = (state_q == S_WAIT) && bus.imem_rvalid && !bus.redirect;
`ifdef XG_IF_BYPASS_EN
        bypass      = !head_valid && rvalid_keep;
`else
        bypass      = 1'b0;
`endif
        pop         = head_valid && bus.id_ready && !bus.redirect;
        push        = rvalid_keep && !(bypass && bus.id_ready);
        next_count  = count_q + CW'(push) - CW'(pop);
        issue       = !bus.redirect && !reset
                   && (next_count < CW'(QDEPTH))
                   && ((state_q == S_IDLE) || bus.imem_rvalid);
    end

    // Next-state logic: FSM, fetch PC, queue pointers and occupancy.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            unique case (state_q)
                S_WAIT:  state_d = bus.imem_rvalid ? S_IDLE : S_DROP;
                S_DROP:  state_d = bus.imem_rvalid ? S_IDLE : S_DROP;
                default: state_d = S_IDLE;
            endcase
        end else begin
            count_d = next_count;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (bus.imem_rvalid) begin
                        state_d = issue ? S_WAIT : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, PC and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Queue storage; entries are cleared on reset so the idle head reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_instr_q[i] <= '0;
                q_pc_q[i]    <= '0;
            end
        end else if (push) begin
            q_instr_q[wr_ptr_q] <= bus.imem_rdata;
            q_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    // Memory request and decode-facing outputs.
    always_comb begin
        bus.imem_req  = issue;
        bus.imem_addr = fetch_pc_q;
        bus.id_valid  = head_valid || bypass;
        bus.id_instr  = q_instr_q[rd_ptr_q];
        bus.id_pc     = q_pc_q[rd_ptr_q];
        if (bypass) begin
            bus.id_instr = bus.imem_rdata;
            bus.id_pc    = req_pc_q;
        end
    end

endmodule
